accumulator_32b: RTL and testbench

Sequential signed accumulator sitting around the 32-bit ripple-carry adder: it feeds the adder with the running sum on A and each accepted operand on B, then registers S and the adder's overflow. A `start` pulse opens a batch of `len` operands. Operands arrive over a valid/ready handshake, and the final sum is held behind a valid/ready output handshake with a sticky signed-overflow flag. It sits between an operand source (register file / test harness) and a result consumer.

---
 rtl/accumulator_32b_if.sv | 27 ++
 rtl/accumulator_32b.sv | 124 ++++++++++++
 tb/tb_accumulator_32b.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/accumulator_32b_if.sv
// Operand/result handshake bundle for accumulator_32b.
// The master side is the operand source and result consumer; the slave side is the accumulator.
interface accumulator_32b_if #(
  parameter int LEN_W  = 8,
  parameter int DATA_W = 32
);
  logic                     start;
  logic [LEN_W-1:0]         len;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] sum;
  logic                     overflow;
  logic                     busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, sum, overflow, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, sum, overflow, busy
  );
endinterface

// File: rtl/accumulator_32b.sv
// Batch signed accumulator around a ripple-carry adder with a sticky overflow flag.
// Define ACCUMULATOR_SATURATE_EN to clamp the running sum on overflow instead of wrapping.
module accumulator_32b #(
  parameter int LEN_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  accumulator_32b_if.slave  bus
);

`ifdef ACCUMULATOR_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] acc_p1;
  logic                     ovf_p1;
  logic [LEN_W-1:0]         rem_p1;
  logic                     in_ready_r;
  logic                     vld_p1;
  logic                     busy_r;

  logic [DATA_W:0]          carry;
  logic signed [DATA_W-1:0] add_s;
  logic                     ovf_now;
  logic signed [DATA_W-1:0] acc_next;

  // On signed overflow the sign of A tells which rail the true sum ran past.
  function automatic logic signed [DATA_W-1:0] resolve_sum(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] s,
    input logic                     ovf
  );
    if (SAT_EN && ovf)
      return a[DATA_W-1] ? SAT_MIN : SAT_MAX;
    return s;
  endfunction

  // Stage p0: combinational ripple-carry add of running sum and incoming operand
  assign carry[0] = 1'b0;
  for (genvar i = 0; i < DATA_W; i++) begin : g_rca
    assign add_s[i]   = acc_p1[i] ^ bus.in_data[i] ^ carry[i];
    assign carry[i+1] = (acc_p1[i] & bus.in_data[i]) |
                        (carry[i] & (acc_p1[i] ^ bus.in_data[i]));
  end
  assign ovf_now  = carry[DATA_W] ^ carry[DATA_W-1];
  assign acc_next = resolve_sum(acc_p1, add_s, ovf_now);

  // Stage p1: FSM, accumulator and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc_p1     <= '0;
      ovf_p1     <= 1'b0;
      rem_p1     <= '0;
      in_ready_r <= 1'b0;
      vld_p1     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc_p1 <= '0;
            ovf_p1 <= 1'b0;
            rem_p1 <= bus.len;
            busy_r <= 1'b1;
            if (bus.len == '0) begin
              state  <= DONE;
              vld_p1 <= 1'b1;
            end else begin
              state      <= ACC;
              in_ready_r <= 1'b1;
            end
          end
        end
        ACC: begin
          if (bus.in_valid) begin
            acc_p1 <= acc_next;
            ovf_p1 <= ovf_p1 | ovf_now;
            rem_p1 <= rem_p1 - 1'b1;
            // Leaving at rem == 1 keeps rem from ever wrapping below zero.
            if (rem_p1 == LEN_W'(1)) begin
              state      <= DONE;
              in_ready_r <= 1'b0;
              vld_p1     <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state  <= IDLE;
            vld_p1 <= 1'b0;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_r <= 1'b0;
          vld_p1     <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = vld_p1;
  assign bus.sum       = acc_p1;
  assign bus.overflow  = ovf_p1;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_accumulator_32b.sv
// Directed self-checking bench for accumulator_32b (wrap or saturate build).
module tb_accumulator_32b;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  accumulator_32b_if acc_if ();

  accumulator_32b dut (
    .clk (clk),
    .rst (rst),
    .bus (acc_if)
  );

`ifdef ACCUMULATOR_SATURATE_EN
  localparam logic [31:0] EXP_POS_OVF  = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_NEG_OVF  = 32'h8000_0000;
  localparam logic [31:0] EXP_TWICE    = 32'h7FFF_FFFE;
`else
  localparam logic [31:0] EXP_POS_OVF  = 32'h8000_0000;
  localparam logic [31:0] EXP_NEG_OVF  = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_TWICE    = 32'h7FFF_FFFF;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch(input logic [7:0] n);
    acc_if.start = 1'b1;
    acc_if.len   = n;
    step();
    acc_if.start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] d);
    acc_if.in_valid = 1'b1;
    acc_if.in_data  = d;
    step();
    acc_if.in_valid = 1'b0;
  endtask

  task automatic accept();
    acc_if.out_ready = 1'b1;
    step();
    acc_if.out_ready = 1'b0;
  endtask

  initial begin
    acc_if.start     = 1'b0;
    acc_if.len       = '0;
    acc_if.in_valid  = 1'b0;
    acc_if.in_data   = '0;
    acc_if.out_ready = 1'b0;

    // Reset then idle
    step();
    step();
    rst = 1'b0;
    check("rst_sum", acc_if.sum, 32'd0);
    check("rst_ovf", {31'd0, acc_if.overflow}, 32'd0);
    check("rst_out_valid", {31'd0, acc_if.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, acc_if.in_ready}, 32'd0);
    check("rst_busy", {31'd0, acc_if.busy}, 32'd0);
    acc_if.in_valid = 1'b1;
    acc_if.in_data  = 32'd99;
    step();
    step();
    acc_if.in_valid = 1'b0;
    check("idle_ignore_sum", acc_if.sum, 32'd0);
    check("idle_ignore_ready", {31'd0, acc_if.in_ready}, 32'd0);

    // Basic batch: 5 - 2 + 10
    start_batch(8'd3);
    check("basic_in_ready", {31'd0, acc_if.in_ready}, 32'd1);
    check("basic_busy", {31'd0, acc_if.busy}, 32'd1);
    feed(32'd5);
    feed(-32'sd2);
    check("basic_not_yet", {31'd0, acc_if.out_valid}, 32'd0);
    check("basic_partial", acc_if.sum, 32'd3);
    feed(32'd10);
    check("basic_out_valid", {31'd0, acc_if.out_valid}, 32'd1);
    check("basic_sum", acc_if.sum, 32'd13);
    check("basic_ovf", {31'd0, acc_if.overflow}, 32'd0);
    check("basic_ready_low", {31'd0, acc_if.in_ready}, 32'd0);
    accept();
    check("basic_accepted", {31'd0, acc_if.out_valid}, 32'd0);
    check("basic_idle_busy", {31'd0, acc_if.busy}, 32'd0);

    // Bubbles and output backpressure
    start_batch(8'd2);
    feed(32'd7);
    for (int i = 0; i < 3; i++) step();
    check("bubble_hold_sum", acc_if.sum, 32'd7);
    check("bubble_no_valid", {31'd0, acc_if.out_valid}, 32'd0);
    feed(32'd8);
    check("bubble_sum", acc_if.sum, 32'd15);
    acc_if.start = 1'b1;
    acc_if.len   = 8'd5;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_valid", {31'd0, acc_if.out_valid}, 32'd1);
      check("bp_sum", acc_if.sum, 32'd15);
      check("bp_in_ready", {31'd0, acc_if.in_ready}, 32'd0);
    end
    acc_if.start = 1'b0;
    accept();
    check("bp_idle", {31'd0, acc_if.in_ready}, 32'd0);
    check("bp_released", {31'd0, acc_if.out_valid}, 32'd0);

    // Positive overflow
    start_batch(8'd2);
    feed(32'h7FFF_FFFF);
    check("povf_first", {31'd0, acc_if.overflow}, 32'd0);
    feed(32'd1);
    check("povf_flag", {31'd0, acc_if.overflow}, 32'd1);
    check("povf_sum", acc_if.sum, EXP_POS_OVF);
    accept();
    check("povf_kept", {31'd0, acc_if.overflow}, 32'd1);

    // Follow-up batch clears the sticky flag
    start_batch(8'd1);
    check("follow_clear", {31'd0, acc_if.overflow}, 32'd0);
    feed(32'd4);
    check("follow_sum", acc_if.sum, 32'd4);
    check("follow_ovf", {31'd0, acc_if.overflow}, 32'd0);
    accept();

    // Negative overflow
    start_batch(8'd2);
    feed(32'h8000_0000);
    feed(32'hFFFF_FFFF);
    check("novf_flag", {31'd0, acc_if.overflow}, 32'd1);
    check("novf_sum", acc_if.sum, EXP_NEG_OVF);
    accept();

    // Adds continue from the wrapped or saturated value
    start_batch(8'd3);
    feed(32'h7FFF_FFFF);
    feed(32'd1);
    feed(32'hFFFF_FFFF);
    check("cont_sum", acc_if.sum, EXP_TWICE);
    check("cont_flag", {31'd0, acc_if.overflow}, 32'd1);
    accept();

    // Zero-length batch
    start_batch(8'd0);
    check("len0_valid", {31'd0, acc_if.out_valid}, 32'd1);
    check("len0_sum", acc_if.sum, 32'd0);
    check("len0_in_ready", {31'd0, acc_if.in_ready}, 32'd0);
    accept();

    // Maximum batch length
    start_batch(8'd255);
    for (int i = 0; i < 255; i++) begin
      feed(32'd1);
      if (i == 253) check("len255_not_yet", {31'd0, acc_if.out_valid}, 32'd0);
    end
    check("len255_valid", {31'd0, acc_if.out_valid}, 32'd1);
    check("len255_sum", acc_if.sum, 32'd255);
    accept();

    // Reset mid-batch discards the partial sum
    start_batch(8'd4);
    feed(32'd1);
    feed(32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_sum", acc_if.sum, 32'd0);
    check("midrst_in_ready", {31'd0, acc_if.in_ready}, 32'd0);
    check("midrst_busy", {31'd0, acc_if.busy}, 32'd0);
    start_batch(8'd1);
    feed(32'hFFFF_FFFF);
    check("midrst_new_sum", acc_if.sum, 32'hFFFF_FFFF);
    check("midrst_new_ovf", {31'd0, acc_if.overflow}, 32'd0);
    check("midrst_new_valid", {31'd0, acc_if.out_valid}, 32'd1);
    accept();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
